// File: rtl/sid_bus_if.sv
// Host-bus front end for the SID core: synchronises and deglitches phi2, captures the bus
// transaction, and produces write strobes, a masked read output enable and a stretched core reset.
module sid_bus_if #(
  parameter int             ADDR_W      = 5,
  parameter int             DATA_W      = 8,
  parameter int             NCS         = 4,
  parameter int             FILT        = 2,
  parameter int             OE_HOLD     = 2,
  parameter logic [NCS-1:0] OE_MASK     = 4'b0001,
  parameter int             RES_STRETCH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              phi2_in,
  input  logic              res_n_in,
  input  logic              r_w_n_in,
  input  logic [NCS-1:0]    cs_n_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] rdata,
  output logic              phi2,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic [NCS-1:0]    cs_sel,
  output logic [NCS-1:0]    we,
  output logic              rd_en,
  output logic [DATA_W-1:0] data_o,
  output logic              data_oe,
  output logic              bus_res,
  output logic              cs_conflict
);

  localparam int FW = $clog2(FILT + 1);
  localparam int HW = $clog2(OE_HOLD + 1);
  localparam int RW = $clog2(RES_STRETCH + 1);

  typedef enum logic [1:0] {
    PHI1 = 2'd0,
    PHI2 = 2'd1,
    HOLD = 2'd2
  } state_t;

  function automatic logic [NCS-1:0] lowest_low(input logic [NCS-1:0] cs_n);
    lowest_low = '0;
    for (int i = NCS - 1; i >= 0; i--) begin
      if (!cs_n[i]) begin
        lowest_low    = '0;
        lowest_low[i] = 1'b1;
      end
    end
  endfunction

  logic              phi2_s1_q, phi2_s2_q;
  logic              res_s1_q, res_s2_q;
  logic              rw_smp_q, rw_cap_q;
  logic [NCS-1:0]    cs_smp_q, cs_cap_q;
  logic [ADDR_W-1:0] addr_smp_q, addr_q;
  logic [DATA_W-1:0] data_smp_q, wdata_q;
  logic              phi2_q;
  logic [FW-1:0]     filt_cnt_q;
  state_t            state_q, state_d;
  logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
  logic [NCS-1:0]    cs_sel_q, cs_sel_d;
  logic [NCS-1:0]    we_q, we_d;
  logic              conflict_q, conflict_d;
  logic              armed_q, armed_d;
  logic              oe_q, oe_d;
  logic [DATA_W-1:0] data_o_q;
  logic [RW-1:0]     res_cnt_q;
  logic [NCS-1:0]    cs_low;
  logic              cs_multi;
  logic              rd_en_c;

  // ps1 and the single-sampled bus are aligned, so capture stops on the sample taken before the pin fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phi2_s1_q  <= 1'b0;
      phi2_s2_q  <= 1'b0;
      res_s1_q   <= 1'b1;
      res_s2_q   <= 1'b1;
      rw_smp_q   <= 1'b1;
      cs_smp_q   <= '1;
      addr_smp_q <= '0;
      data_smp_q <= '0;
      rw_cap_q   <= 1'b1;
      cs_cap_q   <= '1;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      phi2_s1_q  <= phi2_in;
      phi2_s2_q  <= phi2_s1_q;
      res_s1_q   <= res_n_in;
      res_s2_q   <= res_s1_q;
      rw_smp_q   <= r_w_n_in;
      cs_smp_q   <= cs_n_in;
      addr_smp_q <= addr_in;
      data_smp_q <= data_in;
      if (phi2_s1_q) begin
        rw_cap_q <= rw_smp_q;
        cs_cap_q <= cs_smp_q;
        addr_q   <= addr_smp_q;
        wdata_q  <= data_smp_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phi2_q     <= 1'b0;
      filt_cnt_q <= '0;
    end else if (phi2_s2_q != phi2_q) begin
      if (filt_cnt_q == FW'(FILT - 1)) begin
        phi2_q     <= phi2_s2_q;
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + 1'b1;
      end
    end else begin
      filt_cnt_q <= '0;
    end
  end

  assign cs_low   = ~cs_cap_q;
  assign cs_multi = |(cs_low & (cs_low - 1'b1));
  assign rd_en_c  = ((state_q == PHI2) || (state_q == HOLD)) && rw_cap_q && (|cs_sel_q);

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    cs_sel_d   = cs_sel_q;
    we_d       = '0;
    conflict_d = 1'b0;
    armed_d    = armed_q;
    case (state_q)
      PHI1: begin
        if (phi2_q) begin
          state_d  = PHI2;
          cs_sel_d = lowest_low(cs_cap_q);
        end
      end
      PHI2: begin
        cs_sel_d = lowest_low(cs_cap_q);
        if (!phi2_q) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
          armed_d    = 1'b1;
          conflict_d = cs_multi;
          // The first fall after reset may belong to a torn access, so it never strobes.
          if (armed_q && !rw_cap_q) we_d = cs_sel_q;
        end
      end
      HOLD: begin
        if (phi2_q) begin
          state_d  = PHI2;
          cs_sel_d = lowest_low(cs_cap_q);
        end else if (hold_cnt_q == HW'(OE_HOLD - 1)) begin
          state_d = PHI1;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = PHI1;
    endcase
    oe_d = rd_en_c && (|(cs_sel_q & OE_MASK)) && (state_d != PHI1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= PHI1;
      hold_cnt_q <= '0;
      cs_sel_q   <= '0;
      we_q       <= '0;
      conflict_q <= 1'b0;
      armed_q    <= 1'b0;
      oe_q       <= 1'b0;
      data_o_q   <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      cs_sel_q   <= cs_sel_d;
      we_q       <= we_d;
      conflict_q <= conflict_d;
      armed_q    <= armed_d;
      oe_q       <= oe_d;
      if (state_q == PHI2) data_o_q <= rdata;
    end
  end

  // Synced /RES reloads the stretch; the counter starts loaded so rst release also stretches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_cnt_q <= RW'(RES_STRETCH);
    end else if (!res_s2_q) begin
      res_cnt_q <= RW'(RES_STRETCH);
    end else if (res_cnt_q != '0) begin
      res_cnt_q <= res_cnt_q - 1'b1;
    end
  end

  assign phi2        = phi2_q;
  assign addr        = addr_q;
  assign wdata       = wdata_q;
  assign cs_sel      = cs_sel_q;
  assign we          = we_q;
  assign rd_en       = rd_en_c;
  assign data_o      = data_o_q;
  assign data_oe     = oe_q;
  assign bus_res     = !res_s2_q || (res_cnt_q != '0);
  assign cs_conflict = conflict_q;

endmodule
